// File: rtl/oserdes_pkg.sv
// Shared types and default word patterns for the serializer word sequencer.
package oserdes_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_e;

  localparam logic [7:0] TRAIN_PATTERN_DEFAULT = 8'h0F;
  localparam logic [7:0] IDLE_PATTERN_DEFAULT  = 8'h00;

endpackage

// File: rtl/oserdes_word_sequencer.sv
// Word-clock controller for an 8:1 serializer: owns serdes reset and oce,
// runs reset/training bring-up, then streams valid/ready words with idle fill.
module oserdes_word_sequencer
  import oserdes_pkg::*;
#(
  parameter int         RST_CYCLES    = 4,
  parameter int         TRAIN_WORDS   = 8,
  parameter logic [7:0] TRAIN_PATTERN = TRAIN_PATTERN_DEFAULT,
  parameter logic [7:0] IDLE_PATTERN  = IDLE_PATTERN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        retrain,
  output logic        serdes_rst,
  output logic        oce,
  output logic [7:0]  d,
  output logic        link_up,
  output logic [15:0] words_sent
);

  localparam int CNT_MAX = (RST_CYCLES > TRAIN_WORDS) ? RST_CYCLES : TRAIN_WORDS;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_WORDS - 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          serdes_rst_q, serdes_rst_d;
  logic          oce_q, oce_d;
  logic [7:0]    d_q, d_d;
  logic          link_up_q, link_up_d;
  logic [15:0]   words_q, words_d;
  logic          accept;

  // The retrain cycle never accepts, so a presented word is held, not lost.
  assign s_ready = (state_q == ST_RUN) && !retrain;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_TRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TRAIN: begin
        if (retrain) begin
          cnt_d = '0;
        end else if (cnt_q == TRAIN_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (retrain) begin
          state_d = ST_TRAIN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch on the same
  // edge as the state itself (serdes_rst and oce move together).
  always_comb begin
    serdes_rst_d = 1'b1;
    oce_d        = 1'b0;
    d_d          = IDLE_PATTERN;
    link_up_d    = 1'b0;
    case (state_d)
      ST_TRAIN: begin
        serdes_rst_d = 1'b0;
        oce_d        = 1'b1;
        d_d          = TRAIN_PATTERN;
      end
      ST_RUN: begin
        serdes_rst_d = 1'b0;
        oce_d        = 1'b1;
        d_d          = accept ? s_data : IDLE_PATTERN;
        link_up_d    = 1'b1;
      end
      default: begin
        serdes_rst_d = 1'b1;
        oce_d        = 1'b0;
        d_d          = IDLE_PATTERN;
        link_up_d    = 1'b0;
      end
    endcase
    words_d = accept ? words_q + 16'd1 : words_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      serdes_rst_q <= 1'b1;
      oce_q        <= 1'b0;
      d_q          <= IDLE_PATTERN;
      link_up_q    <= 1'b0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      serdes_rst_q <= serdes_rst_d;
      oce_q        <= oce_d;
      d_q          <= d_d;
      link_up_q    <= link_up_d;
      words_q      <= words_d;
    end
  end

  assign serdes_rst = serdes_rst_q;
  assign oce        = oce_q;
  assign d          = d_q;
  assign link_up    = link_up_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_oserdes_word_sequencer.sv
// Directed bench for oserdes_word_sequencer with default parameters.
module tb_oserdes_word_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sData;
  logic        sValid;
  logic        sReady;
  logic        retrain;
  logic        serdesRst;
  logic        oce;
  logic [7:0]  d;
  logic        linkUp;
  logic [15:0] wordsSent;

  int testCount = 0;
  int failCount = 0;

  oserdes_word_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (sData),
    .s_valid    (sValid),
    .s_ready    (sReady),
    .retrain    (retrain),
    .serdes_rst (serdesRst),
    .oce        (oce),
    .d          (d),
    .link_up    (linkUp),
    .words_sent (wordsSent)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data,
                               input logic rtr);
    sValid  = valid;
    sData   = data;
    retrain = rtr;
    #1;
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    checkOutput("rstSerdesRst", serdesRst, 1);
    checkOutput("rstOce", oce, 0);
    checkOutput("rstD", d, 16'h00);
    checkOutput("rstLinkUp", linkUp, 0);
    checkOutput("rstWords", wordsSent, 0);
    checkOutput("rstReady", sReady, 0);

    // Bring-up: 4 reset cycles, 8 training words, then link up.
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("bringSerdesRstHigh", serdesRst, 1);
      checkOutput("bringOceLow", oce, 0);
    end
    tick();
    checkOutput("trainSerdesRstLow", serdesRst, 0);
    checkOutput("trainOce", oce, 1);
    checkOutput("trainFirstD", d, 16'h0F);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput("trainD", d, 16'h0F);
      checkOutput("trainLinkLow", linkUp, 0);
      checkOutput("trainReadyLow", sReady, 0);
    end
    tick();
    checkOutput("runLinkUp", linkUp, 1);
    checkOutput("runIdleD", d, 16'h00);
    checkOutput("runReady", sReady, 1);

    // Back-to-back streaming.
    applyStimulus(1'b1, 8'h0F, 1'b0); tick(); checkOutput("stream0", d, 16'h0F);
    applyStimulus(1'b1, 8'h05, 1'b0); tick(); checkOutput("stream1", d, 16'h05);
    applyStimulus(1'b1, 8'h06, 1'b0); tick(); checkOutput("stream2", d, 16'h06);
    applyStimulus(1'b1, 8'h0F, 1'b0); tick(); checkOutput("stream3", d, 16'h0F);
    applyStimulus(1'b0, 8'hEE, 1'b0); tick();
    checkOutput("streamIdle", d, 16'h00);
    checkOutput("streamWords", wordsSent, 16'd4);

    // Gaps filled with idle.
    applyStimulus(1'b1, 8'hA5, 1'b0); tick(); checkOutput("gap0", d, 16'hA5);
    applyStimulus(1'b0, 8'hFF, 1'b0); tick(); checkOutput("gap1", d, 16'h00);
    applyStimulus(1'b1, 8'h3C, 1'b0); tick(); checkOutput("gap2", d, 16'h3C);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("gapWords", wordsSent, 16'd6);

    // Retrain in RUN with a word pending: word is held until link returns.
    applyStimulus(1'b1, 8'h77, 1'b1);
    checkOutput("retrainReadyLow", sReady, 0);
    tick();
    checkOutput("retrainLinkDown", linkUp, 0);
    checkOutput("retrainD", d, 16'h0F);
    checkOutput("retrainWordsHeld", wordsSent, 16'd6);
    applyStimulus(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput("retrainTrainD", d, 16'h0F);
      checkOutput("retrainLinkLow", linkUp, 0);
    end
    tick();
    checkOutput("retrainLinkBack", linkUp, 1);
    checkOutput("retrainIdleD", d, 16'h00);
    tick();
    checkOutput("retrainHeldWord", d, 16'h77);
    checkOutput("retrainWords", wordsSent, 16'd7);

    // Retrain during TRAIN restarts the full training run.
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (4) tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput("restartLinkLow", linkUp, 0);
      checkOutput("restartD", d, 16'h0F);
    end
    tick();
    checkOutput("restartLinkUp", linkUp, 1);

    // Async reset between edges mid-RUN.
    applyStimulus(1'b1, 8'h5A, 1'b0); tick();
    checkOutput("preRstD", d, 16'h5A);
    applyStimulus(1'b0, 8'h00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncSerdesRst", serdesRst, 1);
    checkOutput("asyncOce", oce, 0);
    checkOutput("asyncD", d, 16'h00);
    checkOutput("asyncWords", wordsSent, 0);
    checkOutput("asyncLink", linkUp, 0);

    // Retrain held through RESET must not stretch the reset phase.
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("rstRetrainSerdesRst", serdesRst, 1);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("rstRetrainToTrain", serdesRst, 0);
    repeat (7) tick();
    checkOutput("rstRetrainLinkLow", linkUp, 0);
    tick();
    checkOutput("rstRetrainLinkUp", linkUp, 1);

    // words_sent wraps after 65536 accepts.
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      tick();
    end
    checkOutput("wrapPre", wordsSent, 16'hFFFF);
    checkOutput("wrapLastD", d, 16'hFE);
    applyStimulus(1'b1, 8'hC3, 1'b0);
    tick();
    checkOutput("wrapZero", wordsSent, 16'h0000);
    checkOutput("wrapD", d, 16'hC3);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/oserdes_word_sequencer.md
# oserdes_word_sequencer

Word-rate controller placed in front of the 8:1 output serializer (d1..d8 / oce / rst ports of the serdes wrapper). It owns the serializer's reset and output-clock-enable, runs a fixed bring-up sequence, then feeds 8-bit words from a valid/ready source, filling gaps with an idle pattern. Runs entirely in the divided word-clock domain that drives the serializer's clkdiv.

## Interface
Parameters:
- RST_CYCLES, 4: word-clock cycles serdes_rst is held high after rst release (≥1).
- TRAIN_WORDS, 8: number of training words sent before link-up (≥1).
- TRAIN_PATTERN, 8'h0F: word driven during training.
- IDLE_PATTERN, 8'h00: word driven in RUN when no data is accepted.

Ports:
- clk  in  1  word clock (serializer clkdiv); all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  8  word to serialize; bit 0 → d1, i.e. the first bit on the wire.
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid && s_ready at a rising edge.
- retrain  in  1  single-cycle request to re-run training.
- serdes_rst  out  1  to serializer rst.
- oce  out  1  to serializer oce.
- d  out  8  to serializer d1..d8 (d[0]→d1 … d[7]→d8).
- link_up  out  1  high in RUN.
- words_sent  out  16  count of accepted words, wraps 16'hFFFF→0.

## Operation
- States (2-bit, encoding RESET=0, TRAIN=1, RUN=2): RESET → TRAIN → RUN, RUN → TRAIN on retrain.
- Async rst: state=RESET, cnt=0, serdes_rst=1, oce=0, d=IDLE_PATTERN, words_sent=0, link_up=0, s_ready=0.
- RESET: serdes_rst=1, oce=0, d=IDLE_PATTERN; cnt increments each cycle; at cnt==RST_CYCLES-1 → TRAIN, cnt←0.
- TRAIN: serdes_rst=0, oce=1, d=TRAIN_PATTERN; cnt increments; at cnt==TRAIN_WORDS-1 → RUN, cnt←0.
- RUN: serdes_rst=0, oce=1; each edge d←s_data if accepted, else IDLE_PATTERN; words_sent+1 per accept.
- s_ready = (state==RUN) && !retrain (combinational); a word is never dropped, the retrain cycle simply does not accept.
- retrain in RUN → TRAIN next edge, cnt←0, link_up falls same edge. retrain in TRAIN → cnt←0 (training restarts, full TRAIN_WORDS). retrain in RESET ignored.
- Counter width $clog2(max(RST_CYCLES,TRAIN_WORDS))+1; no other arithmetic.
- rst mid-operation: immediate return to RESET values regardless of state; words_sent cleared.

## Timing
- All outputs registered except s_ready.
- Data latency: word accepted at edge k appears on d after edge k (one word-clock cycle from s_data sampled to d stable); serializer latency is external.
- After rst falls: serdes_rst stays high for exactly RST_CYCLES edges; first TRAIN word on d after edge RST_CYCLES; link_up and s_ready high after edge RST_CYCLES+TRAIN_WORDS.
- serdes_rst and oce change on the same edge (RESET→TRAIN); oce never high while serdes_rst high.
- Back-to-back accepts sustain one word per cycle, no bubbles.

## Structure
- Shared package oserdes_pkg: state typedef/encoding, default TRAIN_PATTERN and IDLE_PATTERN constants.
- Single module; no sub-modules — FSM, bring-up counter, output register and words_sent counter in one file.

## Test plan
- Reset bring-up, defaults: release rst → serdes_rst high 4 cycles, then d=8'h0F with oce=1 for 8 cycles, then link_up=1, d=8'h00.
- Streaming: with s_valid held, send 8'h0F,8'h05,8'h06,8'h0F on consecutive cycles → d shows same sequence one cycle later, no idle gaps, words_sent=4.
- Gaps: valid pattern 1,0,1 with 8'hA5, x, 8'h3C → d = A5, 00, 3C; words_sent=2.
- Retrain in RUN with s_valid=1: s_ready=0 that cycle, word held; d=8'h0F for 8 cycles, then held word emitted first.
- Retrain during TRAIN at word 5 → training restarts, 8 further training words before link_up; retrain during RESET has no effect.
- Async rst asserted mid-RUN between edges → serdes_rst=1, oce=0, d=8'h00, words_sent=0 immediately; words_sent wrap checked by preloading 16'hFFFF-style run of 65536 accepts → 0.
